// File: rtl/udp_tx_serializer.sv
// udp_tx_serializer
// Captures one 32-bit payload word, builds the 8-byte UDP header around it
// (ones-complement checksum accumulated one 16-bit term per cycle), and streams
// the 12-byte datagram MSB-first over a valid/ready byte interface with
// first/last-byte markers. An optional inter-frame gap follows each datagram.

module udp_tx_serializer #(
    parameter logic [15:0] SRC_PORT   = 16'h0001,
    parameter logic [15:0] DST_PORT   = 16'h0002,
    parameter logic [15:0] UDP_LEN    = 16'h000C,
    parameter int          IFG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        dval_in,
    output logic        in_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [7:0]  drop_cnt
);

    localparam logic [15:0] UDP_PROTO = 16'h0011;
    localparam int          GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [2:0]  TERM_LAST = 3'd5;
    localparam logic [3:0]  BYTE_LAST = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CSUM = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      payload;
    logic [15:0]      acc;
    logic [2:0]       term_idx;
    logic [3:0]       byte_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      term;
    logic [15:0]      csum;
    logic [7:0]       frame_byte;
    logic             xfer;
    logic             accept;

    // 16-bit ones-complement add with end-around carry
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Final checksum: complement of the sum; an all-zero result goes out as all-ones
    function automatic logic [15:0] csum_final(input logic [15:0] sum);
        logic [15:0] c;
        c = ~sum;
        return (c == 16'h0000) ? 16'hFFFF : c;
    endfunction

    assign accept = (state == IDLE) && dval_in;
    assign xfer   = (state == SEND) && tx_ready;
    assign csum   = csum_final(acc);

    // Checksum term presented in each CSUM cycle
    always_comb begin
        term = 16'h0000;
        case (term_idx)
            3'd0:    term = SRC_PORT;
            3'd1:    term = DST_PORT;
            3'd2:    term = UDP_PROTO;
            3'd3:    term = UDP_LEN;
            3'd4:    term = payload[31:16];
            3'd5:    term = payload[15:0];
            default: term = 16'h0000;
        endcase
    end

    // Datagram byte selected by the current byte index
    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            4'd0:    frame_byte = SRC_PORT[15:8];
            4'd1:    frame_byte = SRC_PORT[7:0];
            4'd2:    frame_byte = DST_PORT[15:8];
            4'd3:    frame_byte = DST_PORT[7:0];
            4'd4:    frame_byte = UDP_LEN[15:8];
            4'd5:    frame_byte = UDP_LEN[7:0];
            4'd6:    frame_byte = csum[15:8];
            4'd7:    frame_byte = csum[7:0];
            4'd8:    frame_byte = payload[31:24];
            4'd9:    frame_byte = payload[23:16];
            4'd10:   frame_byte = payload[15:8];
            4'd11:   frame_byte = payload[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-decoded outputs (drop with reset, no register delay)
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_sof     = 1'b0;
        tx_eof     = 1'b0;
        tx_byte    = 8'h00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (dval_in) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (term_idx == TERM_LAST) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_byte  = frame_byte;
                tx_sof   = (byte_idx == 4'd0);
                tx_eof   = (byte_idx == BYTE_LAST);
                if (tx_ready && (byte_idx == BYTE_LAST)) begin
                    state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Term, byte and gap sequencing counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_idx <= 3'd0;
            byte_idx <= 4'd0;
            gap_cnt  <= '0;
        end else begin
            term_idx <= (state == CSUM) ? term_idx + 3'd1 : 3'd0;
            if (state != SEND) begin
                byte_idx <= 4'd0;
            end else if (xfer) begin
                byte_idx <= byte_idx + 4'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    // Payload capture and checksum accumulation (datapath, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            payload <= data_in;
            acc     <= 16'h0000;
        end else if (state == CSUM) begin
            acc <= ones_add(acc, term);
        end
    end

    // Saturating count of payload words offered while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (dval_in && !in_ready && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_udp_tx_serializer.sv
// Testbench for udp_tx_serializer: scoreboard of expected datagram bytes,
// pushed when a word is accepted and popped on every byte transfer.

module tb_udp_tx_serializer;

    localparam int IFG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        dval_in;
    logic        in_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic [7:0]  drop_cnt;

    udp_tx_serializer #(
        .SRC_PORT  (16'h0001),
        .DST_PORT  (16'h0002),
        .UDP_LEN   (16'h000C),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .dval_in (dval_in),
        .in_ready(in_ready),
        .tx_byte (tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_sof  (tx_sof),
        .tx_eof  (tx_eof),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {sof, eof, byte}
    logic [9:0] q[$];

    // Bench model of block state
    logic       model_idle;
    logic       in_gap;
    int         gap_left;
    int         drop_model;
    int         cyc_n;
    int         acc_cyc;
    logic       frame_active;
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic       prev_sof;
    logic       prev_eof;
    int         n_xfer;
    int         n_sof;
    int         n_eof;
    int         n_frames;
    int         byte_in_frame;
    logic       rand_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checksum by wide summation then folding of carries
    function automatic logic [15:0] model_csum(input logic [31:0] d);
        logic [31:0] s;
        s = 32'h0001 + 32'h0002 + 32'h0011 + 32'h000C + {16'h0, d[31:16]} + {16'h0, d[15:0]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s[15:0] = ~s[15:0];
        if (s[15:0] == 16'h0000) s[15:0] = 16'hFFFF;
        return s[15:0];
    endfunction

    task automatic push_frame(input logic [31:0] d);
        logic [7:0]  b[12];
        logic [15:0] c;
        c = model_csum(d);
        b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h00; b[3] = 8'h02;
        b[4] = 8'h00; b[5] = 8'h0C; b[6] = c[15:8]; b[7] = c[7:0];
        b[8] = d[31:24]; b[9] = d[23:16]; b[10] = d[15:8]; b[11] = d[7:0];
        for (int i = 0; i < 12; i++) q.push_back({(i == 0), (i == 11), b[i]});
    endtask

    // One clock cycle: observe at the falling edge, then step past the rising edge
    task automatic cyc();
        logic       cur_idle;
        logic [9:0] e;
        @(negedge clk);
        cyc_n++;
        cur_idle = model_idle;
        chk("in_ready", in_ready, cur_idle);
        chk("drop_cnt", drop_cnt, drop_model);
        if (prev_stall) begin
            chk("hold_valid", tx_valid, 1'b1);
            chk("hold_byte", tx_byte, prev_byte);
            chk("hold_sof", tx_sof, prev_sof);
            chk("hold_eof", tx_eof, prev_eof);
        end
        if (frame_active) chk("no_bubble", tx_valid, 1'b1);
        if (tx_valid && !frame_active) begin
            chk("latency", cyc_n - acc_cyc, 7);
            frame_active = 1'b1;
            byte_in_frame = 0;
        end
        if (in_gap) begin
            gap_left--;
            if (gap_left == 0) begin
                in_gap = 1'b0;
                model_idle = 1'b1;
            end
        end
        if (tx_valid && tx_ready) begin
            chk("q_nonempty", (q.size() != 0), 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("tx_byte", tx_byte, e[7:0]);
                chk("tx_sof", tx_sof, e[9]);
                chk("tx_eof", tx_eof, e[8]);
                n_xfer++;
                byte_in_frame++;
                if (tx_sof) n_sof++;
                if (tx_eof) n_eof++;
                if (e[8]) begin
                    frame_active = 1'b0;
                    n_frames++;
                    if (IFG == 0) begin
                        model_idle = 1'b1;
                    end else begin
                        in_gap = 1'b1;
                        gap_left = IFG;
                    end
                end
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        prev_sof   = tx_sof;
        prev_eof   = tx_eof;
        if (dval_in && cur_idle) begin
            push_frame(data_in);
            model_idle = 1'b0;
            acc_cyc = cyc_n;
        end else if (dval_in && !cur_idle && drop_model < 255) begin
            drop_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int bound);
        int n;
        n = 0;
        while ((q.size() != 0 || !model_idle) && n < bound) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        chk("frame_timeout", (n < bound), 1'b1);
        tx_ready = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d);
        data_in = d;
        dval_in = 1'b1;
        cyc();
        dval_in = 1'b0;
    endtask

    task automatic clear_counts();
        n_xfer = 0;
        n_sof = 0;
        n_eof = 0;
        n_frames = 0;
    endtask

    initial begin
        int n;
        model_idle = 1'b1; in_gap = 1'b0; gap_left = 0; drop_model = 0;
        cyc_n = 0; acc_cyc = 0; frame_active = 1'b0; prev_stall = 1'b0;
        prev_byte = 8'h00; prev_sof = 1'b0; prev_eof = 1'b0;
        byte_in_frame = 0; rand_ready = 1'b0;
        clear_counts();
        rst = 1'b1; data_in = 32'h0; dval_in = 1'b0; tx_ready = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_sof", tx_sof, 1'b0);
        chk("rst_tx_eof", tx_eof, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_drop_cnt", drop_cnt, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc();

        // T1: nominal frame
        clear_counts();
        send_word(32'h12345678);
        run_until_done(100);
        chk("t1_xfers", n_xfer, 12);
        chk("t1_sof", n_sof, 1);
        chk("t1_eof", n_eof, 1);

        // T2: checksum with double end-around carry
        clear_counts();
        send_word(32'hFFFFFFFF);
        run_until_done(100);
        chk("t2_xfers", n_xfer, 12);

        // T3: zero checksum transmitted as all-ones
        clear_counts();
        send_word(32'hFFDF0000);
        run_until_done(100);
        chk("t3_xfers", n_xfer, 12);

        // T4: random back-pressure
        clear_counts();
        rand_ready = 1'b1;
        tx_ready = 1'b0;
        send_word(32'h12345678);
        run_until_done(500);
        rand_ready = 1'b0;
        chk("t4_xfers", n_xfer, 12);
        chk("t4_sof", n_sof, 1);
        chk("t4_eof", n_eof, 1);

        // T5: dval held high, back-to-back frames and drop saturation
        clear_counts();
        tx_ready = 1'b1;
        dval_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            data_in = 32'hA5000000 + i * 32'h00010203;
            cyc();
        end
        dval_in = 1'b0;
        run_until_done(200);
        chk("t5_drop_sat", drop_cnt, 8'hFF);
        chk("t5_frames_ge12", (n_frames >= 12), 1'b1);
        chk("t5_xfers", n_xfer, n_frames * 12);

        // T6: reset during SEND at byte index 5
        send_word(32'hCAFEBABE);
        n = 0;
        while (!(frame_active && byte_in_frame == 5) && n < 50) begin
            cyc();
            n++;
        end
        chk("t6_reach_idx5", (n < 50), 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", tx_valid, 1'b0);
        chk("t6_sof_drop", tx_sof, 1'b0);
        chk("t6_eof_drop", tx_eof, 1'b0);
        q.delete();
        model_idle = 1'b1; in_gap = 1'b0; gap_left = 0; drop_model = 0;
        frame_active = 1'b0; prev_stall = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_drop_clr", drop_cnt, 8'h00);
        cyc();
        clear_counts();
        send_word(32'h0BADF00D);
        run_until_done(100);
        chk("t6_xfers", n_xfer, 12);
        chk("t6_eof", n_eof, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
